multiboot_req_ctrl: RTL

//  Host-facing front end for the multiboot reconfiguration path; sits directly upstream of multiboot_ctrl.

---
 rtl/multiboot_pkg.sv | 38 +++
 rtl/multiboot_req_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/multiboot_pkg.sv
// Shared definitions for the multiboot request front end: FSM encoding,
// register word indices, STATUS bit positions and the default trigger key.
package multiboot_pkg;

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StCountdown = 2'd1,
      StFire      = 2'd2,
      StFail      = 2'd3
   } state_e;

   localparam logic [1:0] RegBootAddr = 2'd0;
   localparam logic [1:0] RegCtrl     = 2'd1;
   localparam logic [1:0] RegStatus   = 2'd2;
   localparam logic [1:0] RegRsvd     = 2'd3;

   localparam int unsigned StatFailBit     = 7;
   localparam int unsigned StatErrKeyBit   = 6;
   localparam int unsigned StatErrAlignBit = 5;
   localparam int unsigned StatBusyBit     = 4;

   localparam logic [31:0] TrigKeyDefault = 32'hB007_5AFE;

   // Assemble the STATUS word from its fields.
   function automatic logic [31:0] status_word(input state_e st, input logic fail,
                                               input logic err_key, input logic err_align,
                                               input logic busy);
      logic [31:0] w;
      w                  = '0;
      w[1:0]             = st;
      w[StatBusyBit]     = busy;
      w[StatErrAlignBit] = err_align;
      w[StatErrKeyBit]   = err_key;
      w[StatFailBit]     = fail;
      return w;
   endfunction

endpackage

// File: rtl/multiboot_req_ctrl.sv
// Host-facing multiboot request controller: boot address register, keyed
// trigger, grace-delay countdown, held request level and reload watchdog.
module multiboot_req_ctrl
   import multiboot_pkg::*;
#(
   parameter int unsigned DELAY_CYCLES   = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 100000000,
   parameter int unsigned ALIGN_BITS     = 16,
   parameter logic [31:0] TRIG_KEY       = TrigKeyDefault
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_reg_wr_en,
   input  logic        i_reg_rd_en,
   input  logic [1:0]  i_reg_addr,
   input  logic [31:0] i_reg_wr_data,
   output logic [31:0] o_reg_rd_data,
   output logic        o_reg_rd_valid,
   output logic        o_ctrl_en,
   output logic [31:0] o_boot_addr,
   output logic        o_busy,
   output logic        o_fail
);

   localparam int unsigned CntMax = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES
                                                                    : TIMEOUT_CYCLES;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam logic [CntW-1:0] DelayLoad   = CntW'(DELAY_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [25:0]     AlignMask   = 26'((64'd1 << ALIGN_BITS) - 64'd1);

   state_e          state;
   logic [CntW-1:0] cnt;
   logic [25:0]     boot_addr_q;
   logic            err_key;
   logic            err_align;
   logic [31:0]     rd_mux;

   logic wr_ctrl, ctrl_zero, key_hit, addr_ok, idle_like, accept, abort, cnt_zero;

   // Decode of host writes against the current state.
   always_comb begin
      wr_ctrl   = i_reg_wr_en && (i_reg_addr == RegCtrl);
      ctrl_zero = (i_reg_wr_data == 32'd0);
      key_hit   = (i_reg_wr_data == TRIG_KEY);
      addr_ok   = ((boot_addr_q & AlignMask) == 26'd0);
      idle_like = (state == StIdle) || (state == StFail);
      accept    = idle_like && wr_ctrl && key_hit && addr_ok;
      abort     = (state == StCountdown) && wr_ctrl && ctrl_zero;
      cnt_zero  = (cnt == '0);
   end

   // Control FSM with registered request, busy and fail outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= StIdle;
         o_ctrl_en   <= 1'b0;
         o_busy      <= 1'b0;
         o_fail      <= 1'b0;
         o_boot_addr <= '0;
      end else begin
         case (state)
            StIdle, StFail: begin
               if (accept) begin
                  state       <= StCountdown;
                  o_busy      <= 1'b1;
                  o_fail      <= 1'b0;
                  o_boot_addr <= {6'b0, boot_addr_q};
               end else if (wr_ctrl && ctrl_zero) begin
                  state  <= StIdle;
                  o_fail <= 1'b0;
               end
            end
            StCountdown: begin
               if (abort) begin
                  state  <= StIdle;
                  o_busy <= 1'b0;
               end else if (cnt_zero) begin
                  state     <= StFire;
                  o_ctrl_en <= 1'b1;
               end
            end
            StFire: begin
               // No abort path once fired; only the watchdog ends this state.
               if (cnt_zero) begin
                  state     <= StFail;
                  o_ctrl_en <= 1'b0;
                  o_busy    <= 1'b0;
                  o_fail    <= 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Shared down-counter: grace delay in COUNTDOWN, watchdog in FIRE.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= DelayLoad;
      end else if ((state == StCountdown) && !abort && cnt_zero) begin
         cnt <= TimeoutLoad;
      end else if (((state == StCountdown) || (state == StFire)) && !cnt_zero) begin
         cnt <= cnt - CntW'(1);
      end
   end

   // Read multiplexer; sees pre-write values so a same-cycle write is not visible.
   always_comb begin
      rd_mux = '0;
      unique case (i_reg_addr)
         RegBootAddr: rd_mux = {6'b0, boot_addr_q};
         RegStatus:   rd_mux = status_word(state, o_fail, err_key, err_align, o_busy);
         default:     rd_mux = '0;
      endcase
   end

   // Register file: boot address, error flags and the read response.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         boot_addr_q    <= '0;
         err_key        <= 1'b0;
         err_align      <= 1'b0;
         o_reg_rd_data  <= '0;
         o_reg_rd_valid <= 1'b0;
      end else begin
         o_reg_rd_valid <= i_reg_rd_en;
         if (i_reg_rd_en) begin
            o_reg_rd_data <= rd_mux;
         end
         if (idle_like && i_reg_wr_en && (i_reg_addr == RegBootAddr)) begin
            boot_addr_q <= i_reg_wr_data[25:0];
         end
         if (idle_like && wr_ctrl) begin
            if (ctrl_zero) begin
               err_key   <= 1'b0;
               err_align <= 1'b0;
            end else if (key_hit) begin
               if (!addr_ok) err_align <= 1'b1;
            end else begin
               err_key <= 1'b1;
            end
         end
      end
   end

endmodule
